// File: rtl/pwm_duty_decoder_if.sv
// Bundle of the PWM decoder's control input, PWM input and measurement results.
// The master side drives ena/pwm_in; the slave side (the decoder) drives results.
interface pwm_duty_decoder_if #(
   parameter int CNT_W = 16
);
   logic             ena;
   logic             pwm_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic [3:0]       duty_tenths;
   logic             valid;
   logic             busy;
   logic             overrun;
   logic             stuck_hi;
   logic             stuck_lo;
   logic [1:0]       dbg_state;

   // valid/overrun are single-cycle pulses with no ready: a consumer must sample
   // the results on the cycle valid is high, they hold until the next update.
   modport master (
      output ena, pwm_in,
      input  period_out, high_out, duty_tenths, valid, busy, overrun,
      input  stuck_hi, stuck_lo, dbg_state
   );

   modport slave (
      input  ena, pwm_in,
      output period_out, high_out, duty_tenths, valid, busy, overrun,
      output stuck_hi, stuck_lo, dbg_state
   );
endinterface

// File: rtl/pwm_duty_decoder.sv
// PWM period/high-time/duty decoder with stuck detection and a serial divider.
// Optional 3-sample majority glitch filter: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input logic              clk,
   input logic              rst_n,
   pwm_duty_decoder_if.slave bus
);
   localparam int               REM_W  = CNT_W + 4;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             sync1_q, sync2_q, p_q;
   logic             s, rise, timeout, rem_ge;
   logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
   logic             armed_q;
   logic [CNT_W-1:0] per_q, hi_q;
   logic [REM_W-1:0] rem_q, h10;
   logic [3:0]       quo_q;
   logic [CNT_W-1:0] period_q, high_q;
   logic [3:0]       duty_q;
   logic             valid_q, overrun_q, stuck_hi_q, stuck_lo_q;

`ifdef PWM_DEC_GLITCH_FILTER_EN
   logic hist1_q, hist2_q;

   // Majority of three consecutive samples rejects single-cycle pulses.
   assign s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
      end else if (bus.ena) begin
         hist1_q <= sync2_q;
         hist2_q <= hist1_q;
      end
   end
`else
   assign s = sync2_q;
`endif

   always_comb begin
      rise    = s & ~p_q;
      timeout = (pcnt_q == TO_VAL) && !rise && !stuck_hi_q && !stuck_lo_q;
      rem_ge  = (rem_q >= {4'b0000, per_q});
      h10     = ({4'b0000, hcnt_q} << 3) + ({4'b0000, hcnt_q} << 1);
      pcnt_d  = pcnt_q;
      hcnt_d  = hcnt_q;
      if (rise) begin
         pcnt_d = CNT_W'(1);
         hcnt_d = CNT_W'(1);
      end else begin
         if (pcnt_q != TO_VAL) pcnt_d = pcnt_q + CNT_W'(1);
         if (s && (hcnt_q != TO_VAL)) hcnt_d = hcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         p_q        <= 1'b0;
         pcnt_q     <= '0;
         hcnt_q     <= '0;
         armed_q    <= 1'b0;
         per_q      <= '0;
         hi_q       <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         period_q   <= '0;
         high_q     <= '0;
         duty_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         stuck_hi_q <= 1'b0;
         stuck_lo_q <= 1'b0;
      end else if (bus.ena) begin
         sync1_q   <= bus.pwm_in;
         sync2_q   <= sync1_q;
         p_q       <= s;
         pcnt_q    <= pcnt_d;
         hcnt_q    <= hcnt_d;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;

         // A measurement arriving while the divider is still working is dropped.
         if (rise) begin
            if (!armed_q) begin
               armed_q <= 1'b1;
            end else if (state_q == IDLE) begin
               per_q   <= pcnt_q;
               hi_q    <= hcnt_q;
               rem_q   <= h10;
               quo_q   <= '0;
               state_q <= DIV;
            end else begin
               overrun_q <= 1'b1;
            end
         end

         case (state_q)
            DIV: begin
               if (rem_ge && (quo_q != 4'd10)) begin
                  rem_q <= rem_q - {4'b0000, per_q};
                  quo_q <= quo_q + 4'd1;
               end else begin
                  period_q   <= per_q;
                  high_q     <= hi_q;
                  duty_q     <= quo_q;
                  valid_q    <= 1'b1;
                  stuck_hi_q <= 1'b0;
                  stuck_lo_q <= 1'b0;
                  state_q    <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: ;
         endcase

         // Timeout can only fire in IDLE since the divider finishes long before.
         if (timeout) begin
            stuck_hi_q <= s;
            stuck_lo_q <= ~s;
            duty_q     <= s ? 4'd10 : 4'd0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b1;
            armed_q    <= 1'b0;
         end
      end else begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end
   end

   assign bus.period_out  = period_q;
   assign bus.high_out    = high_q;
   assign bus.duty_tenths = duty_q;
   assign bus.valid       = valid_q & bus.ena;
   assign bus.overrun     = overrun_q & bus.ena;
   assign bus.busy        = (state_q == DIV) || (state_q == DONE);
   assign bus.stuck_hi    = stuck_hi_q;
   assign bus.stuck_lo    = stuck_lo_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: every result pulse is logged and compared
// against hand-computed period/high/duty values.
module tb_pwm_duty_decoder;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ovr_cnt;
  int   n_before;

  logic [15:0] res_per[$];
  logic [15:0] res_hi[$];
  logic [3:0]  res_duty[$];
  logic        res_shi[$];
  logic        res_slo[$];

  pwm_duty_decoder_if #(.CNT_W(16)) bus ();

  pwm_duty_decoder #(.CNT_W(16), .TIMEOUT(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // result log
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      res_per.push_back(bus.period_out);
      res_hi.push_back(bus.high_out);
      res_duty.push_back(bus.duty_tenths);
      res_shi.push_back(bus.stuck_hi);
      res_slo.push_back(bus.stuck_lo);
    end
    if (bus.overrun === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_log();
    res_per.delete();
    res_hi.delete();
    res_duty.delete();
    res_shi.delete();
    res_slo.delete();
    ovr_cnt = 0;
  endtask

  // driver tasks
  task automatic cyc(input logic v);
    bus.pwm_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic pwm_periods(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) cyc(i < hi);
    end
  endtask

  task automatic do_reset();
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic check_results(input string tag, input int n, input int per, input int hi, input int duty);
    chk({tag, "_count"}, res_per.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_period"}, res_per[i], per);
      chk({tag, "_high"}, res_hi[i], hi);
      chk({tag, "_duty"}, res_duty[i], duty);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    ovr_cnt = 0;
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", bus.period_out, 0);
    chk("rst_high", bus.high_out, 0);
    chk("rst_duty", bus.duty_tenths, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stuck", {bus.stuck_hi, bus.stuck_lo}, 0);
    chk("rst_state", bus.dbg_state, 0);
    do_reset();

    // 1: 10/5, first rise only arms
    pwm_periods(10, 5, 1);
    chk("t1_arm_no_valid", res_per.size(), 0);
    pwm_periods(10, 5, 5);
    hold(1'b0, 16);
    check_results("t1", 5, 10, 5, 5);
    chk("t1_stuck", {bus.stuck_hi, bus.stuck_lo}, 0);

    // 2: 7/3 -> floor(30/7)=4
    do_reset();
    pwm_periods(7, 3, 5);
    hold(1'b0, 16);
    check_results("t2", 4, 7, 3, 4);

    // ena low freezes everything and suppresses pulses
    bus.ena = 1'b0;
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1);
    chk("ena_no_valid", res_per.size(), 4);
    chk("ena_valid_low", bus.valid, 0);
    chk("ena_hold_period", bus.period_out, 7);
    chk("ena_hold_duty", bus.duty_tenths, 4);
    bus.ena = 1'b1;

    // 3: stuck high, then resume 10/3
    do_reset();
    pwm_periods(10, 5, 3);
    hold(1'b1, 100);
    chk("t3_count", res_per.size(), 4);
    for (int i = 0; i < 3; i++) begin
      chk("t3_pre_period", res_per[i], 10);
      chk("t3_pre_duty", res_duty[i], 5);
      chk("t3_pre_shi", res_shi[i], 0);
    end
    chk("t3_to_period", res_per[3], 0);
    chk("t3_to_high", res_hi[3], 0);
    chk("t3_to_duty", res_duty[3], 10);
    chk("t3_to_shi", res_shi[3], 1);
    chk("t3_flag_hi", bus.stuck_hi, 1);
    chk("t3_flag_lo", bus.stuck_lo, 0);
    chk("t3_out_duty", bus.duty_tenths, 10);
    clear_log();
    hold(1'b0, 7);
    pwm_periods(10, 3, 1);
    chk("t3_rearm_no_valid", res_per.size(), 0);
    chk("t3_rearm_keeps_stuck", bus.stuck_hi, 1);
    pwm_periods(10, 3, 3);
    hold(1'b0, 16);
    check_results("t3r", 3, 10, 3, 3);
    chk("t3r_first_shi", res_shi[0], 0);
    chk("t3r_flag_hi", bus.stuck_hi, 0);

    // 4: stuck low
    clear_log();
    hold(1'b0, 80);
    chk("t4_count", res_per.size(), 1);
    chk("t4_period", res_per[0], 0);
    chk("t4_high", res_hi[0], 0);
    chk("t4_duty", res_duty[0], 0);
    chk("t4_slo", res_slo[0], 1);
    chk("t4_shi", res_shi[0], 0);
    chk("t4_flag_lo", bus.stuck_lo, 1);

    // 5: 4/2, every other capture lands while busy
    do_reset();
    pwm_periods(4, 2, 9);
    hold(1'b0, 16);
    check_results("t5", 4, 4, 2, 5);
    chk("t5_overruns", ovr_cnt, 4);

    // 6: reset in the middle of a division
    do_reset();
    pwm_periods(10, 5, 3);
    chk("t6_pre_period", bus.period_out, 10);
    hold(1'b1, 4);
    chk("t6_busy", bus.busy, 1);
    chk("t6_state_div", bus.dbg_state, 1);
    n_before = res_per.size();
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    #1;
    chk("t6_rst_period", bus.period_out, 0);
    chk("t6_rst_high", bus.high_out, 0);
    chk("t6_rst_duty", bus.duty_tenths, 0);
    chk("t6_rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 16);
    chk("t6_lost_result", res_per.size(), n_before);
    clear_log();
    pwm_periods(10, 5, 1);
    chk("t6_arm_no_valid", res_per.size(), 0);
    pwm_periods(10, 5, 2);
    hold(1'b0, 16);
    check_results("t6", 2, 10, 5, 5);

`ifdef PWM_DEC_GLITCH_FILTER_EN
    // single-cycle glitch inside the low phase is filtered out
    do_reset();
    for (int k = 0; k < 4; k++) begin
      hold(1'b1, 5);
      cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    end
    hold(1'b0, 16);
    check_results("glitch", 3, 10, 5, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Measures an incoming PWM waveform, such as the output of our 10-step duty-cycle PWM generator.
- Reports the period and high time in clk cycles, plus the duty cycle in tenths (0..10) as a 4-bit code.
- Used for loopback self-test of the generator and for reading external PWM inputs on ui pins.
- Contains an input synchronizer, edge-timed counters, a timeout/stuck detector and a sequential repeated-subtraction divider.

Parameters:
- CNT_W, 16: width of the period/high counters and of the period_out/high_out ports.
- TIMEOUT, 1000: cycles without a rising edge before the input is declared stuck. Legal range is 16 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous, active-low).
- ena  in  1  clock enable. When low, all state is frozen and all outputs hold.
- pwm_in  in  1  asynchronous PWM input.
- period_out  out  CNT_W  last measured period in cycles; 0 when stuck.
- high_out  out  CNT_W  last measured high time in cycles; 0 when stuck.
- duty_tenths  out  4  floor(high*10/period), range 0..10.
- valid  out  1  one-cycle pulse when the three result outputs above update.
- busy  out  1  high while the divider is running.
- overrun  out  1  one-cycle pulse when a completed period is discarded.
- stuck_hi  out  1  level flag: input held high for TIMEOUT cycles.
- stuck_lo  out  1  level flag: input held low for TIMEOUT cycles.

Behaviour:
- Reset: all outputs and internal registers are 0, the FSM is in IDLE, and the decoder is disarmed.
- Synchronizer:
  - pwm_in passes through a 2-flop synchronizer to give s; p is s delayed by one cycle.
  - A rising edge is s=1 and p=0.
- Counters:
  - pcnt counts cycles since the last rising edge.
  - hcnt counts cycles with s=1 since the last rising edge.
  - On a rising edge both are loaded with 1. Otherwise pcnt increments each cycle, and hcnt increments when s=1.
  - Both counters saturate at TIMEOUT.
- Arming:
  - The first rising edge after reset or after a timeout only arms the decoder. No capture occurs.
- Capture, on a rising edge while armed:
  - Latch P=pcnt and H=hcnt.
  - If the FSM is IDLE, start the divider.
  - If the FSM is busy, discard the measurement and pulse overrun. Counters still restart.
- Divider FSM:
  - IDLE: on capture, rem=H*10 (CNT_W+4 bits), q=0, go to DIV.
  - DIV, once per cycle: if rem>=P, then rem-=P and q++; else go to DONE. At most 11 DIV cycles.
  - DONE: period_out=P, high_out=H, duty_tenths=q, pulse valid, clear both stuck flags, go to IDLE.
  - Latency from the capture edge cycle to valid is q+2 cycles, 2..12 in total.
  - busy is high in DIV and DONE.
- Timeout:
  - Trigger: pcnt reaches TIMEOUT with no rising edge in that cycle, while not already stuck.
  - If s=1: set stuck_hi and duty_tenths=10. Otherwise set stuck_lo and duty_tenths=0.
  - In both cases set period_out=0 and high_out=0, pulse valid once, and disarm.
  - The stuck flags clear on the next valid from a real measurement. The rising edge that re-arms the decoder does not clear them.
- Simultaneous events:
  - A rising edge in the timeout cycle wins; no timeout is raised.
  - Timeout cannot coincide with DIV because TIMEOUT>=16.
- ena=0: counters, FSM, synchronizer and outputs all hold. valid and overrun are 0 while ena=0.
- Reset asserted mid-DIV: everything returns to the reset state and the in-progress result is lost.

Optional Feature:
- Macro: PWM_DEC_GLITCH_FILTER_EN.
- When defined:
  - s is the majority of the last 3 synchronizer output samples, so single-cycle pulses and dropouts are ignored.
  - All edges are delayed by 1 extra cycle; period and high-time values for clean input are unchanged.
- When undefined: s is taken directly from the second synchronizer flop, with no filtering.

Test Plan:
1. Generator-style PWM, period 10, high 5, repeated. Expected response:
   - No valid on the first rising edge (arming only).
   - Every 10 cycles after that: valid with period_out=10, high_out=5, duty_tenths=5.
2. Period 7, high 3. Expected: duty_tenths=4 (floor 30/7), period_out=7, high_out=3.
3. Period 10, high 10 then high 0 sequences; TIMEOUT=64 with pwm_in held 1 for 100 cycles. Expected:
   - Exactly one valid, with stuck_hi=1, duty_tenths=10, period_out=0.
   - After resuming period 10/high 3: the first valid has duty_tenths=3 and stuck_hi=0.
4. pwm_in held 0 after activity. Expected: after 64 cycles, stuck_lo=1, duty_tenths=0, a single valid pulse.
5. Period 4, high 2 square wave. Expected:
   - Captures arriving during DIV pulse overrun.
   - Every accepted result reads period_out=4, high_out=2, duty_tenths=5.
6. rst_n low for 1 cycle mid-DIV. Expected:
   - All outputs are 0 immediately.
   - The next rising edge only arms; the first valid comes one full period later.
   - With PWM_DEC_GLITCH_FILTER_EN defined, a 1-cycle high glitch inside a low phase leaves the result unchanged at period 10 / high 5.
